// File: rtl/rv_pkg.sv
// Shared core definitions for the RV32I pipeline: result-select encodings,
// forward-select constants, hazard FSM state type and a register-match helper.
package rv_pkg;

    // Result select encodings carried with each instruction (ResultSrc).
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Operand source selects for the execute-stage ALU inputs.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Width of the memory watchdog counter; MAX_WAIT must fit (2..255).
    localparam int WAIT_CNT_W = 8;

    // Memory-handshake watchdog states.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } hz_state_t;

    // A later stage produces the value of source register rs when it writes
    // a non-zero destination equal to rs (x0 is never forwarded).
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The datapath is the master (drives register ids and memory status),
// the controller is the slave (returns stall/flush/forward controls).
interface hazard_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic [4:0] RdM;
    logic       RegWriteM;
    logic       MemReqM;
    logic [4:0] RdWB;
    logic       RegWriteWB;
    logic       dmem_ready;

    logic       dmem_req;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushWB;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       mem_timeout;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MemReqM, RdWB, RegWriteWB, dmem_ready,
        input  dmem_req, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushWB, ForwardAE, ForwardBE, mem_timeout
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MemReqM, RdWB, RegWriteWB, dmem_ready,
        output dmem_req, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushWB, ForwardAE, ForwardBE, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select for one execute-stage operand: the memory stage result
// is newer than the writeback result, so it takes precedence.
module hazard_ctrl_fwd_sel
    import rv_pkg::*;
(
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_wb,
    input  logic       i_reg_write_wb,
    output logic [1:0] o_fwd
);

    // Choose the youngest in-flight producer of i_rs_e.
    always_comb begin
        o_fwd = FWD_RF;
        if (reg_match(i_reg_write_m, i_rd_m, i_rs_e)) begin
            o_fwd = FWD_MEM;
        end else if (reg_match(i_reg_write_wb, i_rd_wb, i_rs_e)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage RV32I pipeline.
// Owns the data-memory handshake: an unready access freezes PC..EX/MEM and
// bubbles MEM/WB; a watchdog moves to a sticky ERROR state if memory never
// answers within MAX_WAIT cycles. All controls are forced low during reset.
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int MAX_WAIT = 16     // legal range 2..255
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MAX_WAIT - 1);

    hz_state_t             r_state;
    hz_state_t             w_state_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_timeout;
    logic                  w_timeout_next;

    logic                  w_mem_stall;
    logic                  w_lw_stall;
    logic [4:0]            w_rs_e [2];
    logic [1:0]            w_fwd  [2];

    logic                  w_dmem_req;
    logic                  w_stall_f;
    logic                  w_stall_d;
    logic                  w_stall_e;
    logic                  w_stall_m;
    logic                  w_flush_d;
    logic                  w_flush_e;
    logic                  w_flush_wb;

    // Watchdog state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // Next state: count consecutive unready memory cycles and give up on
    // the MAX_WAIT-th one. The RUN cycle that first sees the stall is
    // already unready cycle 1, hence the counter starts at 1.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_timeout_next  = r_timeout;
        case (r_state)
            RUN: begin
                if (hz.MemReqM && !hz.dmem_ready) begin
                    w_state_next    = MEM_WAIT;
                    w_wait_cnt_next = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_state_next    = ERROR;
                    w_timeout_next  = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            ERROR: begin
                // Only reset leaves ERROR; memory responses are ignored.
                w_state_next = ERROR;
            end
            default: begin
                w_state_next    = RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // Hazard detection terms feeding the output decode.
    assign w_mem_stall = (r_state == RUN      && hz.MemReqM && !hz.dmem_ready) ||
                         (r_state == MEM_WAIT && !hz.dmem_ready) ||
                         (r_state == ERROR);

    assign w_lw_stall  = (hz.ResultSrcE == RES_MEM) && (hz.RdE != 5'd0) &&
                         ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Outputs: a memory hold freezes everything and defers load-use and
    // branch handling, since the held ID/EX contents re-evaluate on release.
    always_comb begin
        w_dmem_req = 1'b0;
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_stall_m  = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_flush_wb = 1'b0;
        if (!reset) begin
            w_dmem_req = hz.MemReqM && (r_state != ERROR);
            if (w_mem_stall) begin
                w_stall_f  = 1'b1;
                w_stall_d  = 1'b1;
                w_stall_e  = 1'b1;
                w_stall_m  = 1'b1;
                w_flush_wb = 1'b1;
            end else begin
                w_stall_f  = w_lw_stall;
                w_stall_d  = w_lw_stall;
                w_flush_e  = w_lw_stall || hz.PCSrcE;
                w_flush_d  = hz.PCSrcE;
            end
        end
    end

    assign w_rs_e[0] = hz.Rs1E;
    assign w_rs_e[1] = hz.Rs2E;

    // One forwarding comparator per ALU operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_ctrl_fwd_sel u_fwd_sel (
                .i_rs_e         (w_rs_e[gi]),
                .i_rd_m         (hz.RdM),
                .i_reg_write_m  (hz.RegWriteM),
                .i_rd_wb        (hz.RdWB),
                .i_reg_write_wb (hz.RegWriteWB),
                .o_fwd          (w_fwd[gi])
            );
        end
    endgenerate

    assign hz.dmem_req    = w_dmem_req;
    assign hz.StallF      = w_stall_f;
    assign hz.StallD      = w_stall_d;
    assign hz.StallE      = w_stall_e;
    assign hz.StallM      = w_stall_m;
    assign hz.FlushD      = w_flush_d;
    assign hz.FlushE      = w_flush_e;
    assign hz.FlushWB     = w_flush_wb;
    assign hz.ForwardAE   = reset ? FWD_RF : w_fwd[0];
    assign hz.ForwardBE   = reset ? FWD_RF : w_fwd[1];
    assign hz.mem_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_WAIT = 4): the driver
// applies one vector per cycle and queues its hand-computed response; the
// monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    logic clk;
    logic reset;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [12:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    exp_t        mon_e;
    logic [12:0] mon_act;

    // {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushWB,
    //  ForwardAE, ForwardBE, mem_timeout}
    function automatic logic [12:0] ev(input logic dreq, input logic sf,
                                       input logic sd, input logic se,
                                       input logic sm, input logic fd,
                                       input logic fe, input logic fwb,
                                       input logic [1:0] fa,
                                       input logic [1:0] fb,
                                       input logic to);
        return {dreq, sf, sd, se, sm, fd, fe, fwb, fa, fb, to};
    endfunction

    // Monitor: compare all controller outputs against the queued response.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = {hz.dmem_req, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                       hz.FlushD, hz.FlushE, hz.FlushWB,
                       hz.ForwardAE, hz.ForwardBE, hz.mem_timeout};
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %b required %b", mon_e.name, mon_act, mon_e.val);
            end else begin
                $display("ok   %s: %b", mon_e.name, mon_act);
            end
        end
    end

    task automatic clear_inputs();
        hz.Rs1D       = 5'd0;
        hz.Rs2D       = 5'd0;
        hz.Rs1E       = 5'd0;
        hz.Rs2E       = 5'd0;
        hz.RdE        = 5'd0;
        hz.ResultSrcE = 2'b00;
        hz.PCSrcE     = 1'b0;
        hz.RdM        = 5'd0;
        hz.RegWriteM  = 1'b0;
        hz.MemReqM    = 1'b0;
        hz.RdWB       = 5'd0;
        hz.RegWriteWB = 1'b0;
        hz.dmem_ready = 1'b0;
    endtask

    // Queue the expected response for the vector now on the inputs and
    // advance one cycle.
    task automatic step(input string name, input logic [12:0] e);
        exp_t x;
        x.name = name;
        x.val  = e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    localparam logic [12:0] ZERO = 13'd0;

    initial begin
        logic [12:0] hold_v;
        hold_v = ev(1, 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);

        reset = 1'b1;
        clear_inputs();
        hz.MemReqM   = 1'b1;
        hz.PCSrcE    = 1'b1;
        hz.RegWriteM = 1'b1;
        hz.RdM       = 5'd3;
        hz.Rs1E      = 5'd3;
        @(posedge clk);
        #1;
        step("reset_outputs", ZERO);

        reset = 1'b0;
        clear_inputs();
        step("idle", ZERO);

        // Load-use hazards.
        hz.RdE = 5'd5; hz.ResultSrcE = 2'b01; hz.Rs1D = 5'd5;
        step("lw_use_rs1", ev(0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
        clear_inputs();
        step("lw_next_clean", ZERO);
        hz.RdE = 5'd9; hz.ResultSrcE = 2'b01; hz.Rs1D = 5'd3; hz.Rs2D = 5'd9;
        step("lw_use_rs2", ev(0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
        clear_inputs();
        hz.RdE = 5'd0; hz.ResultSrcE = 2'b01;
        step("lw_x0_ignored", ZERO);
        hz.RdE = 5'd6; hz.ResultSrcE = 2'b00; hz.Rs1D = 5'd6;
        step("alu_no_stall", ZERO);

        // Branch handling.
        clear_inputs();
        hz.RdE = 5'd5; hz.ResultSrcE = 2'b01; hz.Rs1D = 5'd5; hz.PCSrcE = 1'b1;
        step("branch_and_lw", ev(0, 1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
        clear_inputs();
        hz.PCSrcE = 1'b1;
        step("branch_flush", ev(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));

        // Forwarding.
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd7; hz.RegWriteWB = 1'b1; hz.RdWB = 5'd7;
        hz.Rs1E = 5'd7;
        step("fwd_a_mem_wins", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        hz.RdM = 5'd0; hz.Rs2E = 5'd7;
        step("fwd_wb_rdm_zero", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0));
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd4; hz.Rs2E = 5'd4;
        hz.RegWriteWB = 1'b1; hz.RdWB = 5'd7; hz.Rs1E = 5'd7;
        step("fwd_b_mem", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        hz.RegWriteM = 1'b0; hz.RegWriteWB = 1'b0;
        step("fwd_no_write", ZERO);

        // Memory handshake: single-cycle, then ready on the 4th cycle.
        clear_inputs();
        hz.MemReqM = 1'b1; hz.dmem_ready = 1'b1;
        step("mem_single_cycle", ev(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        hz.dmem_ready = 1'b0;
        step("mem_wait_1", hold_v);
        hz.PCSrcE = 1'b1; hz.RdE = 5'd5; hz.ResultSrcE = 2'b01; hz.Rs1D = 5'd5;
        step("mem_wait_2_defer", hold_v);
        hz.RegWriteM = 1'b1; hz.RdM = 5'd8; hz.Rs1E = 5'd8;
        step("mem_wait_3_fwd", ev(1, 1, 1, 1, 1, 0, 0, 1, 2'b10, 2'b00, 0));
        clear_inputs();
        hz.MemReqM = 1'b1; hz.dmem_ready = 1'b1;
        step("mem_ready_4", ev(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        clear_inputs();
        step("mem_back_to_run", ZERO);

        // Reset in the second wait cycle abandons the request.
        hz.MemReqM = 1'b1;
        step("rst_wait_1", hold_v);
        reset = 1'b1;
        step("rst_mid_wait", ZERO);
        reset = 1'b0;
        clear_inputs();
        step("rst_release_idle", ZERO);

        // Watchdog: four unready cycles from a freshly cleared counter.
        hz.MemReqM = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("timeout_wait_%0d", i), hold_v);
        end
        hz.dmem_ready = 1'b1;
        step("err_ignores_ready", ev(0, 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        clear_inputs();
        hz.PCSrcE = 1'b1;
        step("err_sticky", ev(0, 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        reset = 1'b1;
        step("err_reset", ZERO);
        reset = 1'b0;
        clear_inputs();
        step("final_idle", ZERO);

        // Every queued response must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t required finish earlier", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
